// File: rtl/id_ext_pkg.sv
// rtl/id_ext_pkg.sv - extender select constants, FSM states and opcode fields for id_ext_ctrl
package id_ext_pkg;

    localparam logic [5:0] EXT_Z12 = 6'b000001;
    localparam logic [5:0] EXT_S12 = 6'b000010;
    localparam logic [5:0] EXT_S16 = 6'b000100;
    localparam logic [5:0] EXT_S26 = 6'b001000;
    localparam logic [5:0] EXT_F20 = 6'b010000;
    localparam logic [5:0] EXT_Z5  = 6'b100000;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // instr[31:22]
    localparam logic [9:0] OP10_SLTI   = 10'h008;
    localparam logic [9:0] OP10_SLTUI  = 10'h009;
    localparam logic [9:0] OP10_ADDI_W = 10'h00A;
    localparam logic [9:0] OP10_ANDI   = 10'h00D;
    localparam logic [9:0] OP10_ORI    = 10'h00E;
    localparam logic [9:0] OP10_XORI   = 10'h00F;
    localparam logic [9:0] OP10_LD_B   = 10'h0A0;
    localparam logic [9:0] OP10_LD_H   = 10'h0A1;
    localparam logic [9:0] OP10_LD_W   = 10'h0A2;
    localparam logic [9:0] OP10_ST_B   = 10'h0A4;
    localparam logic [9:0] OP10_ST_H   = 10'h0A5;
    localparam logic [9:0] OP10_ST_W   = 10'h0A6;
    localparam logic [9:0] OP10_LD_BU  = 10'h0A8;
    localparam logic [9:0] OP10_LD_HU  = 10'h0A9;

    // instr[31:26]
    localparam logic [5:0] OP6_JIRL = 6'h13;
    localparam logic [5:0] OP6_B    = 6'h14;
    localparam logic [5:0] OP6_BL   = 6'h15;
    localparam logic [5:0] OP6_BEQ  = 6'h16;
    localparam logic [5:0] OP6_BNE  = 6'h17;
    localparam logic [5:0] OP6_BLT  = 6'h18;
    localparam logic [5:0] OP6_BGE  = 6'h19;
    localparam logic [5:0] OP6_BLTU = 6'h1A;
    localparam logic [5:0] OP6_BGEU = 6'h1B;

    // instr[31:25]
    localparam logic [6:0] OP7_LU12I_W   = 7'h0A;
    localparam logic [6:0] OP7_PCADDU12I = 7'h0E;

    // instr[31:15]
    localparam logic [16:0] OP17_SLLI_W = 17'h00081;
    localparam logic [16:0] OP17_SRLI_W = 17'h00089;
    localparam logic [16:0] OP17_SRAI_W = 17'h00091;

endpackage

// File: rtl/id_ext_dec.sv
// rtl/id_ext_dec.sv - combinational immediate-class decoder producing a one-hot extender select
module id_ext_dec
    import id_ext_pkg::*;
(
    input  logic [31:0] instr,
    output logic [5:0]  ext_op,
    output logic        unk
);

    logic [9:0]  op10;
    logic [5:0]  op6;
    logic [6:0]  op7;
    logic [16:0] op17;
    logic        z12, s12, s16, s26, f20, z5;

    assign op10 = instr[31:22];
    assign op6  = instr[31:26];
    assign op7  = instr[31:25];
    assign op17 = instr[31:15];

    // The opcode groups occupy disjoint encodings, so at most one match fires.
    assign z12 = op10 inside {OP10_ANDI, OP10_ORI, OP10_XORI};
    assign s12 = op10 inside {OP10_SLTI, OP10_SLTUI, OP10_ADDI_W,
                              OP10_LD_B, OP10_LD_H, OP10_LD_W,
                              OP10_ST_B, OP10_ST_H, OP10_ST_W,
                              OP10_LD_BU, OP10_LD_HU};
    assign s16 = op6 inside {OP6_JIRL, OP6_BEQ, OP6_BNE, OP6_BLT,
                             OP6_BGE, OP6_BLTU, OP6_BGEU};
    assign s26 = op6 inside {OP6_B, OP6_BL};
    assign f20 = op7 inside {OP7_LU12I_W, OP7_PCADDU12I};
    assign z5  = op17 inside {OP17_SLLI_W, OP17_SRLI_W, OP17_SRAI_W};

    assign ext_op = ({6{z12}} & EXT_Z12) | ({6{s12}} & EXT_S12) |
                    ({6{s16}} & EXT_S16) | ({6{s26}} & EXT_S26) |
                    ({6{f20}} & EXT_F20) | ({6{z5}}  & EXT_Z5);
    assign unk    = ~|ext_op;

endmodule

// File: rtl/id_ext_ctrl.sv
// rtl/id_ext_ctrl.sv - ID stage with immediate-class decode and 2-entry skid buffer; ID_EXT_PERF_EN adds perf counters
module id_ext_ctrl
    import id_ext_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [5:0]      out_ext_op,
    output logic            out_unk,
    input  logic            flush
`ifdef ID_EXT_PERF_EN
    ,
    output logic [31:0]     perf_issue,
    output logic [31:0]     perf_stall
`endif
);

    state_t          state_q;
    logic [XLEN-1:0] main_instr_q, main_pc_q, skid_instr_q, skid_pc_q;
    logic [5:0]      main_op_q, skid_op_q;
    logic            main_unk_q, skid_unk_q;
    logic [5:0]      dec_op_d;
    logic            dec_unk_d;
    logic            in_fire, out_fire;

    id_ext_dec u_dec (
        .instr  (in_instr[31:0]),
        .ext_op (dec_op_d),
        .unk    (dec_unk_d)
    );

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    assign out_instr  = main_instr_q;
    assign out_pc     = main_pc_q;
    assign out_ext_op = main_op_q;
    assign out_unk    = main_unk_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= EMPTY;
            main_instr_q <= '0;
            main_pc_q    <= '0;
            main_op_q    <= '0;
            main_unk_q   <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            skid_op_q    <= '0;
            skid_unk_q   <= 1'b0;
        end else if (flush) begin
            state_q <= EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_instr_q <= in_instr;
                        main_pc_q    <= in_pc;
                        main_op_q    <= dec_op_d;
                        main_unk_q   <= dec_unk_d;
                        state_q      <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_instr_q <= in_instr;
                        main_pc_q    <= in_pc;
                        main_op_q    <= dec_op_d;
                        main_unk_q   <= dec_unk_d;
                    end else if (in_fire) begin
                        skid_instr_q <= in_instr;
                        skid_pc_q    <= in_pc;
                        skid_op_q    <= dec_op_d;
                        skid_unk_q   <= dec_unk_d;
                        state_q      <= FULL;
                    end else if (out_fire) begin
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain path exists.
                    if (out_fire) begin
                        main_instr_q <= skid_instr_q;
                        main_pc_q    <= skid_pc_q;
                        main_op_q    <= skid_op_q;
                        main_unk_q   <= skid_unk_q;
                        state_q      <= ONE;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

`ifdef ID_EXT_PERF_EN
    logic [31:0] perf_issue_q, perf_stall_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (out_fire)
                perf_issue_q <= perf_issue_q + 32'd1;
            if (out_valid && !out_ready)
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_issue = perf_issue_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_id_ext_ctrl.sv
// tb/tb_id_ext_ctrl.sv - self-checking bench for id_ext_ctrl against a queue-based reference model
module tb_id_ext_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid, in_ready, out_valid, out_ready, out_unk, flush;
    logic [31:0] in_instr, in_pc, out_instr, out_pc;
    logic [5:0]  out_ext_op;
`ifdef ID_EXT_PERF_EN
    logic [31:0] perf_issue, perf_stall;
`endif

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int exp_issue = 0;
    int exp_stall = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [5:0]  op;
        logic        unk;
    } ent_t;

    ent_t q[$];

    always #5 clk = ~clk;

    id_ext_ctrl #(.XLEN(32)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_ext_op (out_ext_op),
        .out_unk    (out_unk),
        .flush      (flush)
`ifdef ID_EXT_PERF_EN
        ,
        .perf_issue (perf_issue),
        .perf_stall (perf_stall)
`endif
    );

    function automatic ent_t mk(input logic [31:0] i, input logic [31:0] pc);
        ent_t e;
        e.instr = i;
        e.pc    = pc;
        e.op    = 6'b000000;
        if (i[31:22] inside {10'h00D, 10'h00E, 10'h00F})
            e.op = 6'b000001;
        else if (i[31:22] inside {[10'h008:10'h00A], [10'h0A0:10'h0A2], [10'h0A4:10'h0A6], 10'h0A8, 10'h0A9})
            e.op = 6'b000010;
        else if (i[31:26] == 6'h13 || i[31:26] inside {[6'h16:6'h1B]})
            e.op = 6'b000100;
        else if (i[31:26] inside {6'h14, 6'h15})
            e.op = 6'b001000;
        else if (i[31:25] inside {7'h0A, 7'h0E})
            e.op = 6'b010000;
        else if (i[31:15] inside {17'h00081, 17'h00089, 17'h00091})
            e.op = 6'b100000;
        e.unk = (e.op == 6'b000000);
        return e;
    endfunction

    // One clock of stimulus; the model advances alongside, outputs are sampled 1 time unit after the edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic rdy, input logic fl);
        bit inf, outf;
        in_valid = v; in_instr = ins; in_pc = pc; out_ready = rdy; flush = fl;
        inf  = v && (q.size() < 2);
        outf = rdy && (q.size() > 0);
        if (outf) exp_issue++;
        if (q.size() > 0 && !rdy) exp_stall++;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (outf) void'(q.pop_front());
            if (inf) q.push_back(mk(ins, pc));
        end
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; in_valid = 0; in_instr = 32'hDEAD_BEEF; in_pc = 32'h1234; out_ready = 0; flush = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else pass_cnt++;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else pass_cnt++;
        chk_cnt++; if (out_ext_op !== 6'b0 || out_unk !== 1'b0) $display("FAIL reset_ext got %b/%b exp 000000/0", out_ext_op, out_unk); else pass_cnt++;
        chk_cnt++; if (out_instr !== 32'h0 || out_pc !== 32'h0) $display("FAIL reset_data got %h/%h exp 0/0", out_instr, out_pc); else pass_cnt++;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ori();
        step(1, 32'h0380_0421, 32'h1C00_0000, 1, 0);
        chk_cnt++; if (out_valid !== 1'b1) $display("FAIL ori_valid got %b exp 1", out_valid); else pass_cnt++;
        chk_cnt++; if (out_ext_op !== 6'b000001 || out_unk !== 1'b0) $display("FAIL ori_ext got %b/%b exp 000001/0", out_ext_op, out_unk); else pass_cnt++;
        chk_cnt++; if (out_pc !== 32'h1C00_0000) $display("FAIL ori_pc got %h exp 1c000000", out_pc); else pass_cnt++;
        step(0, 32'h0, 32'h0, 1, 0);
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL ori_drain got %b exp 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [3];
        logic [5:0]  exp [3];
        ins[0] = 32'h5400_0000; ins[1] = 32'h1400_0004; ins[2] = 32'h0040_8400;
        exp[0] = 6'b001000;     exp[1] = 6'b010000;     exp[2] = 6'b100000;
        for (int k = 0; k < 3; k++) begin
            step(1, ins[k], 32'h1C00_0100 + 32'(4 * k), 1, 0);
            chk_cnt++;
            if (out_valid !== 1'b1 || out_ext_op !== exp[k] || out_instr !== ins[k])
                $display("FAIL b2b_%0d got v=%b op=%b i=%h exp v=1 op=%b i=%h", k, out_valid, out_ext_op, out_instr, exp[k], ins[k]);
            else pass_cnt++;
        end
        step(0, 32'h0, 32'h0, 1, 0);
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_drain got %b exp 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        step(1, 32'h0280_0001, 32'hA0, 0, 0);
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready1 got %b exp 1", in_ready); else pass_cnt++;
        step(1, 32'h0280_0002, 32'hA4, 0, 0);
        chk_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_ready2 got %b exp 0", in_ready); else pass_cnt++;
        step(1, 32'h0280_0003, 32'hA8, 0, 0);
        chk_cnt++; if (in_ready !== 1'b0 || out_instr !== 32'h0280_0001) $display("FAIL bp_hold got r=%b i=%h exp r=0 i=02800001", in_ready, out_instr); else pass_cnt++;
        step(1, 32'h0280_0003, 32'hA8, 1, 0);
        chk_cnt++; if (out_valid !== 1'b1 || out_instr !== 32'h0280_0002 || out_pc !== 32'hA4) $display("FAIL bp_second got v=%b i=%h exp v=1 i=02800002", out_valid, out_instr); else pass_cnt++;
        step(1, 32'h0280_0003, 32'hA8, 1, 0);
        chk_cnt++; if (out_valid !== 1'b1 || out_instr !== 32'h0280_0003 || out_pc !== 32'hA8) $display("FAIL bp_third got v=%b i=%h exp v=1 i=02800003", out_valid, out_instr); else pass_cnt++;
        step(0, 32'h0, 32'h0, 1, 0);
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_drain got %b exp 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_flush();
        step(1, 32'h5800_0000, 32'hB0, 0, 0);
        step(1, 32'h5C00_0000, 32'hB4, 0, 0);
        step(1, 32'h0340_0000, 32'hB8, 1, 1);
        chk_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL flush_state got v=%b r=%b exp v=0 r=1", out_valid, in_ready); else pass_cnt++;
        step(0, 32'h0, 32'h0, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_stays_empty got %b exp 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_unknown_and_async_reset();
        step(1, 32'hFFFF_FFFF, 32'hC0, 0, 0);
        chk_cnt++; if (out_ext_op !== 6'b000000 || out_unk !== 1'b1) $display("FAIL unk_decode got %b/%b exp 000000/1", out_ext_op, out_unk); else pass_cnt++;
        step(1, 32'h4C00_0000, 32'hC4, 0, 0);
        chk_cnt++; if (in_ready !== 1'b0) $display("FAIL unk_full got %b exp 0", in_ready); else pass_cnt++;
        #2 rstn = 1'b0;
        #1;
        chk_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 32'h0 || out_pc !== 32'h0 || out_ext_op !== 6'b0 || out_unk !== 1'b0)
            $display("FAIL async_reset got v=%b r=%b i=%h pc=%h op=%b u=%b exp 0/1/0/0/0/0", out_valid, in_ready, out_instr, out_pc, out_ext_op, out_unk);
        else pass_cnt++;
        q.delete();
        exp_issue = 0; exp_stall = 0;
        @(negedge clk);
        rstn = 1'b1;
        step(1, 32'h0380_0421, 32'h1C00_0040, 0, 0);
        chk_cnt++; if (out_valid !== 1'b1 || out_ext_op !== 6'b000001 || out_pc !== 32'h1C00_0040) $display("FAIL post_reset_accept got v=%b op=%b pc=%h", out_valid, out_ext_op, out_pc); else pass_cnt++;
        step(0, 32'h0, 32'h0, 1, 0);
    endtask

    task automatic test_random();
        logic [31:0] base [8];
        logic [31:0] lmask [8];
        logic [31:0] ins;
        int errs;
        base[0] = 32'h0340_0000; lmask[0] = 32'h003F_FFFF;
        base[1] = 32'h0280_0000; lmask[1] = 32'h003F_FFFF;
        base[2] = 32'h2A00_0000; lmask[2] = 32'h003F_FFFF;
        base[3] = 32'h4C00_0000; lmask[3] = 32'h03FF_FFFF;
        base[4] = 32'h6C00_0000; lmask[4] = 32'h03FF_FFFF;
        base[5] = 32'h5000_0000; lmask[5] = 32'h03FF_FFFF;
        base[6] = 32'h1C00_0000; lmask[6] = 32'h01FF_FFFF;
        base[7] = 32'h0048_8000; lmask[7] = 32'h0000_7FFF;
        errs = 0;
        for (int n = 0; n < 400; n++) begin
            int s;
            s = $urandom_range(0, 9);
            if (s < 8) ins = base[s] | ($urandom() & lmask[s]);
            else       ins = $urandom();
            step($urandom_range(0, 3) != 0, ins, $urandom(), $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
            chk_cnt++;
            if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2)) begin
                $display("FAIL rand_hs_%0d got v=%b r=%b exp v=%b r=%b", n, out_valid, in_ready, q.size() != 0, q.size() < 2);
                errs++;
            end else pass_cnt++;
            if (q.size() != 0) begin
                chk_cnt++;
                if (out_instr !== q[0].instr || out_pc !== q[0].pc || out_ext_op !== q[0].op || out_unk !== q[0].unk) begin
                    $display("FAIL rand_data_%0d got %h/%h/%b/%b exp %h/%h/%b/%b", n, out_instr, out_pc, out_ext_op, out_unk,
                             q[0].instr, q[0].pc, q[0].op, q[0].unk);
                    errs++;
                end else pass_cnt++;
            end
            if (errs > 10) break;
        end
`ifdef ID_EXT_PERF_EN
        chk_cnt++; if (perf_issue !== 32'(exp_issue)) $display("FAIL perf_issue got %0d exp %0d", perf_issue, exp_issue); else pass_cnt++;
        chk_cnt++; if (perf_stall !== 32'(exp_stall)) $display("FAIL perf_stall got %0d exp %0d", perf_stall, exp_stall); else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_ori();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_unknown_and_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
